serial_adder_ctrl: RTL and testbench

//   Bit-serial add/subtract engine. Re-uses one 1-bit full-adder cell
//   (ci,a,b -> S,cout) for WIDTH cycles, LSB first, to add or subtract two

---
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell reused LSB-first for WIDTH
// cycles, with a start/busy/done handshake toward the requester.
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic           carry;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic           bit_s;
  logic           bit_c;
  logic           last_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (last_bit) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The shared 1-bit full-adder cell, fed by the bit the counter points at.
  always_comb begin
    bit_s     = carry ^ a_r[cnt] ^ b_r[cnt];
    bit_c     = (a_r[cnt] & b_r[cnt]) | (a_r[cnt] & carry) | (b_r[cnt] & carry);
    last_bit  = (cnt == LAST);
    work_next = work;
    work_next[cnt] = bit_s;
  end

  // Subtraction is a + ~b + 1, so the borrow-free flag falls out as cout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          work  <= work_next;
          carry <= bit_c;
          if (last_bit) begin
            sum  <= work_next;
            cout <= bit_c;
            ovf  <= carry ^ bit_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised self-checking bench for serial_adder_ctrl (WIDTH=4).
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;

  int checks;
  int errors;

  serial_adder_ctrl #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation from an idle negedge and observes it for 10 cycles;
  // operands are scrambled mid-run to prove the latched copies are used.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        input logic icin, input logic isub,
                        output logic [3:0] osum, output logic ocout,
                        output logic oovf, output int busy_n,
                        output int done_at, output int done_n,
                        output bit hold_ok);
    logic [5:0] pre;
    pre     = {sum, cout, ovf};
    hold_ok = 1'b1;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    osum    = 4'hx;
    ocout   = 1'bx;
    oovf    = 1'bx;
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin
        a = 4'($urandom); b = 4'($urandom); cin = ~icin; sub = ~isub;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
        osum  = sum;
        ocout = cout;
        oovf  = ovf;
      end
      if (k < 5 && {sum, cout, ovf} !== pre) hold_ok = 1'b0;
      if (k > 5 && {sum, cout, ovf} !== {osum, ocout, oovf}) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy/done/sum/cout/ovf=%b, expected 00000000",
               {busy, done, sum, cout, ovf});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_add();
    logic [3:0] s; logic c, o; int bn, da, dn; bit h;
    run_op(4'h7, 4'h9, 1'b0, 1'b0, s, c, o, bn, da, dn, h);
    checks++;
    if (bn !== 5) begin errors++; $display("[TB] FAIL add_busy_cycles: got %0d expected 5", bn); end
    checks++;
    if (da !== 5 || dn !== 1) begin
      errors++; $display("[TB] FAIL add_done_pulse: at %0d count %0d expected at 5 count 1", da, dn);
    end
    checks++;
    if ({s, c, o} !== {4'h0, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL add_7_9: got sum=%h cout=%b ovf=%b expected 0 1 0", s, c, o);
    end
    checks++;
    if (!h) begin errors++; $display("[TB] FAIL add_hold: outputs changed outside DONE"); end
  endtask

  task automatic test_add_carry();
    logic [3:0] s; logic c, o; int bn, da, dn; bit h;
    run_op(4'h7, 4'h1, 1'b1, 1'b0, s, c, o, bn, da, dn, h);
    checks++;
    if ({s, c, o} !== {4'h9, 1'b0, 1'b1}) begin
      errors++; $display("[TB] FAIL add_7_1_c: got sum=%h cout=%b ovf=%b expected 9 0 1", s, c, o);
    end
    run_op(4'hF, 4'h1, 1'b1, 1'b0, s, c, o, bn, da, dn, h);
    checks++;
    if ({s, c, o} !== {4'h1, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL add_F_1_c: got sum=%h cout=%b ovf=%b expected 1 1 0", s, c, o);
    end
  endtask

  task automatic test_sub();
    logic [3:0] s; logic c, o; int bn, da, dn; bit h;
    run_op(4'h5, 4'h3, 1'b0, 1'b1, s, c, o, bn, da, dn, h);
    checks++;
    if ({s, c, o} !== {4'h2, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL sub_5_3: got sum=%h cout=%b ovf=%b expected 2 1 0", s, c, o);
    end
    run_op(4'h3, 4'h5, 1'b1, 1'b1, s, c, o, bn, da, dn, h);
    checks++;
    if ({s, c, o} !== {4'hE, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL sub_3_5: got sum=%h cout=%b ovf=%b expected E 0 0", s, c, o);
    end
    run_op(4'h8, 4'h1, 1'b0, 1'b1, s, c, o, bn, da, dn, h);
    checks++;
    if ({s, c, o} !== {4'h7, 1'b1, 1'b1}) begin
      errors++; $display("[TB] FAIL sub_8_1: got sum=%h cout=%b ovf=%b expected 7 1 1", s, c, o);
    end
  endtask

  // Start held high: a second op is accepted 6 cycles after the first,
  // using whatever operands are present at that acceptance edge.
  task automatic test_back_to_back();
    logic [11:0] busy_mask, done_mask;
    logic [5:0]  res1, res2;
    busy_mask = '0; done_mask = '0; res1 = 'x; res2 = 'x;
    a = 4'h3; b = 4'h4; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) begin a = 4'h9; b = 4'h9; cin = 1'b1; sub = 1'b1; end
      busy_mask[k-1] = busy;
      done_mask[k-1] = done;
      if (k == 5)  res1 = {sum, cout, ovf};
      if (k == 11) res2 = {sum, cout, ovf};
    end
    start = 1'b0;
    checks++;
    if (busy_mask !== 12'h7DF) begin
      errors++; $display("[TB] FAIL b2b_busy: got %b expected 011111011111", busy_mask);
    end
    checks++;
    if (done_mask !== 12'h410) begin
      errors++; $display("[TB] FAIL b2b_done: got %b expected 010000010000", done_mask);
    end
    checks++;
    if (res1 !== {4'h7, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL b2b_first: got %b expected 0111_0_0", res1);
    end
    checks++;
    if (res2 !== {4'h0, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL b2b_second: got %b expected 0000_1_0", res2);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s; logic c, o; int bn, da, dn; bit h;
    int late_done;
    a = 4'h7; b = 4'h9; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy/done/sum/cout/ovf=%b expected 00000000",
               {busy, done, sum, cout, ovf});
    end
    rst_n = 1'b1;
    late_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++; $display("[TB] FAIL reset_no_done: %0d busy/done cycles seen expected 0", late_done);
    end
    run_op(4'h2, 4'h3, 1'b0, 1'b0, s, c, o, bn, da, dn, h);
    checks++;
    if ({s, c, o} !== {4'h5, 1'b0, 1'b0} || da !== 5) begin
      errors++; $display("[TB] FAIL reset_fresh_op: got sum=%h cout=%b ovf=%b done@%0d expected 5 0 0 @5",
                         s, c, o, da);
    end
  endtask

  task automatic test_random();
    logic [3:0] ra, rb, beff, s; logic rc, rs, c, o, cin_eff, cm;
    logic [4:0] full; logic [3:0] low;
    int bn, da, dn; bit h;
    for (int n = 0; n < 1000; n++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rc, rs, s, c, o, bn, da, dn, h);
      beff    = rs ? ~rb : rb;
      cin_eff = rs ? 1'b1 : rc;
      full    = {1'b0, ra} + {1'b0, beff} + {4'b0, cin_eff};
      low     = {1'b0, ra[2:0]} + {1'b0, beff[2:0]} + {3'b0, cin_eff};
      cm      = low[3];
      checks++;
      if ({s, c, o} !== {full[3:0], full[4], cm ^ full[4]} || dn !== 1) begin
        errors++;
        $display("[TB] FAIL random_op a=%h b=%h cin=%b sub=%b: got %h %b %b (dones %0d) expected %h %b %b",
                 ra, rb, rc, rs, s, c, o, dn, full[3:0], full[4], cm ^ full[4]);
      end
      checks++;
      if (!h) begin
        errors++; $display("[TB] FAIL random_hold a=%h b=%h: outputs moved outside DONE", ra, rb);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
